// File: rtl/array_result_drain.sv
// Snapshots the 16 systolic-array accumulators a fixed number of cycles after start
// and streams them out as zero-extended 32-bit beats over valid/ready.
module array_result_drain #(
    parameter int RES_W   = 17,
    parameter int NUM_RES = 16,
    parameter int LATENCY = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [NUM_RES*RES_W-1:0] c_in,
    output logic [31:0]              m_data,
    output logic [3:0]               m_index,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_RES - 1);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [RES_W-1:0] buf_q [NUM_RES];
    logic [RES_W-1:0] buf_d [NUM_RES];
    logic [RES_W-1:0] slice [NUM_RES];

    generate
        for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_slice
            assign slice[gi] = c_in[gi*RES_W +: RES_W];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WAIT;
                    cnt_d     = CNT_LOAD;
                    overrun_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (start) overrun_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    // Whole-array capture in one edge; later c_in changes are irrelevant.
                    for (int i = 0; i < NUM_RES; i++) buf_d[i] = slice[i];
                    idx_d   = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (start) overrun_d = 1'b1;
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= 4'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_RES; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

    // idx_q parks at 15 after a drain, so m_last is gated by valid.
    assign m_valid = (state_q == ST_DRAIN);
    assign m_data  = {{(32-RES_W){1'b0}}, buf_q[idx_q]};
    assign m_index = idx_q;
    assign m_last  = m_valid && (idx_q == LAST_IDX);
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_array_result_drain.sv
// Directed bench for array_result_drain: expected beats go into a scoreboard queue
// at start time; a negedge monitor pops and compares every transferred beat.
module tb_array_result_drain;

    localparam int RES_W   = 17;
    localparam int NUM_RES = 16;
    localparam int LATENCY = 10;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b0;
    logic                     start = 1'b0;
    logic [NUM_RES*RES_W-1:0] c_in = '0;
    logic [31:0]              m_data;
    logic [3:0]               m_index;
    logic                     m_valid;
    logic                     m_ready = 1'b1;
    logic                     m_last;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    array_result_drain #(.RES_W(RES_W), .NUM_RES(NUM_RES), .LATENCY(LATENCY)) dut (
        .clk(clk), .resetn(resetn), .start(start), .c_in(c_in),
        .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int first_rel = -1;
    int last_rel = -1;
    int beats = 0;
    logic [RES_W-1:0] vals [NUM_RES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: m_ready is driven just after posedge, so at negedge it shows what the next edge samples.
    logic        hold_pending = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;
    logic        held_last;

    always @(negedge clk) begin
        if (!resetn) begin
            hold_pending = 1'b0;
            prev_valid   = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", {31'b0, m_valid}, 32'd1);
                chk("hold_data", m_data, held_data);
                chk("hold_index", {28'b0, m_index}, {28'b0, held_idx});
                chk("hold_last", {31'b0, m_last}, {31'b0, held_last});
            end
            if (m_valid && !prev_valid) first_rel = cyc - t0;
            if (done) chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=idx%0d required=none", m_index);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_index", {28'b0, m_index}, {28'b0, e.idx});
                    chk("beat_last", {31'b0, m_last}, {31'b0, e.last});
                end
                beats++;
                if (m_index == 4'd15) last_rel = cyc - t0;
            end
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
            held_idx     = m_index;
            held_last    = m_last;
            prev_valid   = m_valid;
            prev_done    = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cin();
        for (int k = 0; k < NUM_RES; k++) c_in[k*RES_W +: RES_W] = vals[k];
    endtask

    // mode 1: ready toggles 1,0,0,1. Starts in the current cycle, which may be a done cycle.
    task automatic run_seq(input bit ready_mode, input bit zero_late, input bit dbl_start,
                           input int rst_at_beat);
        int rel;
        int done_rel;
        bit finished;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int k = 0; k < NUM_RES; k++) begin
            beat_t b;
            b.data = {15'b0, vals[k]};
            b.idx  = 4'(k);
            b.last = (k == NUM_RES - 1);
            exp_q.push_back(b);
        end
        load_cin();
        t0 = cyc;
        first_rel = -1;
        last_rel = -1;
        beats = 0;
        done_rel = -1;
        finished = 1'b0;
        start = 1'b1;
        m_ready = 1'b1;
        for (int n = 0; n < 200 && !finished; n++) begin
            step();
            rel = cyc - t0;
            start = dbl_start && (rel == 5 || rel == 15);
            m_ready = ready_mode ? pat[rel % 4] : 1'b1;
            if (zero_late && rel == LATENCY + 1) c_in = '0;
            if (rel == 3) chk("overrun_cleared", {31'b0, overrun}, 32'd0);
            if (rel == 20) chk("overrun_mid", {31'b0, overrun}, {31'b0, dbl_start});
            if (rst_at_beat >= 0 && beats == rst_at_beat && m_valid) begin
                chk("rst_point_index", {28'b0, m_index}, 32'(rst_at_beat));
                resetn = 1'b0;
                #1;
                chk("rst_valid", {31'b0, m_valid}, 32'd0);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_done", {31'b0, done}, 32'd0);
                chk("rst_overrun", {31'b0, overrun}, 32'd0);
                chk("rst_data", m_data, 32'd0);
                chk("rst_index", {28'b0, m_index}, 32'd0);
                chk("rst_last", {31'b0, m_last}, 32'd0);
                exp_q.delete();
                start = 1'b0;
                step();
                step();
                resetn = 1'b1;
                step();
                return;
            end
            if (done) begin
                done_rel = rel;
                finished = 1'b1;
                chk("busy_low_at_done", {31'b0, busy}, 32'd0);
                chk("overrun_end", {31'b0, overrun}, {31'b0, dbl_start});
            end
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout_no_done actual=none required=done");
        end
        chk("first_valid_cycle", 32'(first_rel), 32'(LATENCY + 1));
        chk("beat_count", 32'(beats), 32'(NUM_RES));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_after_last", 32'(done_rel), 32'(last_rel + 1));
        if (!ready_mode) chk("done_cycle", 32'(done_rel), 32'(LATENCY + 1 + NUM_RES));
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) step();
        chk("reset_valid", {31'b0, m_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_overrun", {31'b0, overrun}, 32'd0);
        chk("reset_data", m_data, 32'd0);
        resetn = 1'b1;
        step();

        // Idle with random c_in: nothing may start.
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NUM_RES; k++) c_in[k*RES_W +: RES_W] = RES_W'($urandom);
            step();
            chk("idle_quiet", {28'b0, m_valid, busy, done, overrun}, 32'd0);
        end

        for (int k = 0; k < NUM_RES; k++) vals[k] = RES_W'(k + 1);
        run_seq(1'b0, 1'b0, 1'b0, -1);
        // Back-to-back calls start in the done cycle itself.
        run_seq(1'b0, 1'b0, 1'b1, -1);
        for (int k = 0; k < NUM_RES; k++) vals[k] = 17'h1FFFF - RES_W'(k);
        run_seq(1'b0, 1'b1, 1'b0, -1);
        for (int k = 0; k < NUM_RES; k++) vals[k] = RES_W'(k + 1);
        run_seq(1'b1, 1'b0, 1'b0, -1);
        step();
        for (int k = 0; k < NUM_RES; k++) vals[k] = RES_W'(17'h100 + k * 3);
        run_seq(1'b0, 1'b0, 1'b0, 7);
        run_seq(1'b0, 1'b0, 1'b0, -1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
